// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the PC fetch sequencer.
package pc_seq_pkg;
  localparam int PC_W = 8;
  typedef logic [PC_W-1:0] pc_t;
  typedef enum logic [1:0] {IDLE, FETCH, HALT, DONE} pc_seq_state_e;
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: instruction-memory request/ack bus with branch redirect and fetch pulse.
interface pc_fetch_sequencer_if #(parameter int N = 8);
  logic imem_req;
  logic [N-1:0] imem_addr;
  logic imem_ack;
  logic branch_valid;
  logic [N-1:0] branch_target;
  logic fetch_valid;
  modport master(output imem_req, imem_addr, fetch_valid, input imem_ack, branch_valid, branch_target);
  modport slave(input imem_req, imem_addr, fetch_valid, output imem_ack, branch_valid, branch_target);
endinterface

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// pc_reg: N-bit PC register with load (priority) and wrapping increment.
module pc_reg #(
  parameter int N = 8,
  parameter logic [N-1:0] START_ADDR = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic [N-1:0] load_data,
  input  logic inc,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= START_ADDR;
    else q <= load ? load_data : inc ? q + N'(1) : q;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: FSM issuing one held imem request per PC, with branch, halt/resume and end stop.
module pc_fetch_sequencer import pc_seq_pkg::*; #(
  parameter int N = 8,
  parameter logic [N-1:0] START_ADDR = '0,
  parameter logic [N-1:0] END_ADDR = N'(3)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic halt_req,
  input  logic resume,
  pc_fetch_sequencer_if.master bus,
  output logic [N-1:0] pc,
  output logic busy,
  output logic done
);
  pc_seq_state_e state, state_d;
  logic acc, load, inc, fv;
  logic [N-1:0] load_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      fv <= 1'b0;
    end else begin
      state <= state_d;
      fv <= acc;
    end
  assign acc = state == FETCH && bus.imem_ack;
  always_comb begin
    state_d = state;
    load = 1'b0;
    load_data = START_ADDR;
    inc = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) begin
        load = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (acc) begin
          if (bus.branch_valid) begin
            load = 1'b1;
            load_data = bus.branch_target;
          end else if (pc == END_ADDR) state_d = DONE;
          else inc = 1'b1;
        end
        // a same-cycle end-address accept has already chosen DONE
        if (state_d == FETCH && halt_req) state_d = HALT;
      end
      HALT: state_d = resume ? FETCH : HALT;
      default: state_d = IDLE;
    endcase
  end
  pc_reg #(.N(N), .START_ADDR(START_ADDR)) u_pc (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .inc(inc), .q(pc)
  );
  assign bus.imem_req = state == FETCH;
  assign bus.imem_addr = pc;
  assign bus.fetch_valid = fv;
  assign busy = state == FETCH || state == HALT;
  assign done = state == DONE;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scenario tests with hand-computed expectations.
module tb_pc_fetch_sequencer;
  import pc_seq_pkg::*;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic busy, done;
  pc_t pc;
  int checks = 0, errors = 0;
  pc_fetch_sequencer_if #(.N(8)) bus();
  pc_fetch_sequencer #(.N(8), .START_ADDR(8'h00), .END_ADDR(8'h03)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .resume(resume),
    .bus(bus), .pc(pc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    bus.imem_ack = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = '0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({bus.imem_req, bus.fetch_valid, busy, done, pc} !== {4'b0000, 8'h00}) begin
      errors++; $display("FAIL reset_state: req/fv/busy/done/pc=%b%b%b%b/%h want 0000/00", bus.imem_req, bus.fetch_valid, busy, done, pc);
    end
    step;
    reset = 1'b0;
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if ({bus.imem_req, bus.fetch_valid, busy, pc} !== {3'b000, 8'h00}) begin
        errors++; $display("FAIL idle_ack_ignored: req/fv/busy/pc=%b%b%b/%h want 000/00", bus.imem_req, bus.fetch_valid, busy, pc);
      end
    end
  endtask
  task automatic test_zero_wait;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.fetch_valid, busy} !== {1'b1, 8'(i), i > 0, 1'b1}) begin
        errors++; $display("FAIL zero_wait_%0d: req/addr/fv/busy=%b/%h/%b/%b want 1/%h/%b/1", i, bus.imem_req, bus.imem_addr, bus.fetch_valid, busy, 8'(i), i > 0);
      end
      step;
    end
    checks++;
    if ({done, bus.imem_req, bus.fetch_valid, busy, pc} !== {4'b1010, 8'h03}) begin
      errors++; $display("FAIL zero_wait_done: done/req/fv/busy/pc=%b%b%b%b/%h want 1010/03", done, bus.imem_req, bus.fetch_valid, busy, pc);
    end
    step;
    checks++;
    if ({done, bus.imem_req, bus.fetch_valid} !== 3'b100) begin
      errors++; $display("FAIL zero_wait_after: done/req/fv=%b%b%b want 100", done, bus.imem_req, bus.fetch_valid);
    end
  endtask
  task automatic test_wait_states;
    bus.imem_ack = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int w = 0; w < 3; w++) begin
        bus.imem_ack = w == 2;
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.fetch_valid, done} !== {1'b1, 8'(f), w == 0 && f > 0, 1'b0}) begin
          errors++; $display("FAIL wait_%0d_%0d: req/addr/fv/done=%b/%h/%b/%b want 1/%h/%b/0", f, w, bus.imem_req, bus.imem_addr, bus.fetch_valid, done, 8'(f), w == 0 && f > 0);
        end
        step;
      end
    checks++;
    if ({done, bus.imem_req, bus.fetch_valid} !== 3'b101) begin
      errors++; $display("FAIL wait_done_12: done/req/fv=%b%b%b want 101", done, bus.imem_req, bus.fetch_valid);
    end
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if ({pc, bus.fetch_valid, done} !== {8'h03, 2'b01}) begin
        errors++; $display("FAIL done_ack_ignored: pc/fv/done=%h/%b%b want 03/01", pc, bus.fetch_valid, done);
      end
    end
  endtask
  task automatic test_branch;
    pc_t exp_addr [8] = '{8'h00, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    bus.imem_ack = 1'b1;
    bus.branch_target = 8'hFE;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.branch_valid = i == 1;
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_addr[i]}) begin
        errors++; $display("FAIL branch_%0d: req/addr=%b/%h want 1/%h", i, bus.imem_req, bus.imem_addr, exp_addr[i]);
      end
      step;
    end
    bus.branch_valid = 1'b0;
    checks++;
    if ({done, bus.imem_req, pc} !== {2'b10, 8'h03}) begin
      errors++; $display("FAIL branch_done: done/req/pc=%b%b/%h want 10/03", done, bus.imem_req, pc);
    end
  endtask
  task automatic test_halt;
    bus.imem_ack = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    bus.imem_ack = 1'b1;
    step;
    halt_req = 1'b1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL halt_pre: req/addr=%b/%h want 1/01", bus.imem_req, bus.imem_addr);
    end
    step;
    halt_req = 1'b0;
    bus.imem_ack = 1'b0;
    checks++;
    if ({pc, bus.imem_req, busy, done, bus.fetch_valid} !== {8'h02, 4'b0101}) begin
      errors++; $display("FAIL halt_entry: pc/req/busy/done/fv=%h/%b%b%b%b want 02/0101", pc, bus.imem_req, busy, done, bus.fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      start = i == 1;
      bus.imem_ack = i == 2;
      step;
      checks++;
      if ({pc, bus.imem_req, busy, bus.fetch_valid} !== {8'h02, 3'b010}) begin
        errors++; $display("FAIL halt_hold_%0d: pc/req/busy/fv=%h/%b%b%b want 02/010", i, pc, bus.imem_req, busy, bus.fetch_valid);
      end
    end
    start = 1'b0;
    bus.imem_ack = 1'b0;
    resume = 1'b1;
    step;
    resume = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL resume: req/addr=%b/%h want 1/02", bus.imem_req, bus.imem_addr);
    end
  endtask
  task automatic test_reset_mid;
    step;
    step;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL mid_wait: req/addr=%b/%h want 1/02", bus.imem_req, bus.imem_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req, pc, busy, bus.fetch_valid} !== {1'b0, 8'h00, 2'b00}) begin
      errors++; $display("FAIL async_reset: req/pc/busy/fv=%b/%h/%b%b want 0/00/00", bus.imem_req, pc, busy, bus.fetch_valid);
    end
    step;
    reset = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL restart: req/addr=%b/%h want 1/00", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1;
    step;
    bus.imem_ack = 1'b0;
    checks++;
    if ({bus.imem_addr, bus.fetch_valid} !== {8'h01, 1'b1}) begin
      errors++; $display("FAIL restart_adv: addr/fv=%h/%b want 01/1", bus.imem_addr, bus.fetch_valid);
    end
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_branch;
    test_halt;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
